// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the BCD counter / seven-segment
// display slice.
//   - SEG_0..SEG_9 : segment patterns {dp,g,f,e,d,c,b,a}, active-high
//   - SEG_BLANK    : all segments off
//   - BCD_MAX      : largest legal BCD digit value
//   - seg_decode() : BCD digit to segment pattern (non-BCD input -> blank)
//   - bcd_sanitize(): maps an illegal nibble (>9) to 0
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Segment pattern for one BCD digit; dp is always off.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    logic [7:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // Illegal BCD nibbles are stored as zero.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nibble);
    logic [3:0] value;
    if (nibble > BCD_MAX) begin
      value = 4'd0;
    end else begin
      value = nibble;
    end
    return value;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade (0..9) of a chained BCD up/down counter.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   load, load_val[3:0] - synchronous load (illegal nibble stored as 0)
//   inc, dec            - count direction qualifiers for this cycle
//   carry_in, borrow_in - this decade steps only when its chain input is high
//   digit[3:0]          - current decade value
//   carry_out           - carry_in while digit is 9 (next decade increments)
//   borrow_out          - borrow_in while digit is 0 (next decade decrements)
module bcd_digit
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       carry_out,
  output logic       borrow_out
);

  logic [3:0] digit_r;

  assign digit      = digit_r;
  assign carry_out  = carry_in & (digit_r == BCD_MAX);
  assign borrow_out = borrow_in & (digit_r == 4'd0);

  // Decade register: load wins over counting, increment over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_r <= 4'd0;
    end else if (load) begin
      digit_r <= bcd_sanitize(load_val);
    end else if (inc && carry_in) begin
      digit_r <= (digit_r >= BCD_MAX) ? 4'd0 : digit_r + 4'd1;
    end else if (dec && borrow_in) begin
      digit_r <= (digit_r == 4'd0) ? BCD_MAX : digit_r - 4'd1;
    end else begin
      digit_r <= digit_r;
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// bcd_counter_display: DIGITS-wide BCD up/down counter with tick divider,
// synchronous load and a time-multiplexed seven-segment driver with optional
// leading-zero blanking.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   ud                - 1 = count up, 0 = count down (sampled on tick cycle)
//   en                - count enable (display scanning never stops)
//   load, load_val    - synchronous load strobe and BCD value (digit 0 low)
//   count             - current BCD value
//   wrap              - one-cycle pulse on 9..9 -> 0..0 or 0..0 -> 9..9
//   SEG_DATA          - segments {dp,g,f,e,d,c,b,a}, active-high, registered
//   SEG_SEL           - one-hot digit select, bit i = digit i, registered
module bcd_counter_display
  import seg_pkg::*;
#(
  parameter int CLK_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int DIGITS   = 4,
  parameter int LZB      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ud,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7:0]            SEG_DATA,
  output logic [DIGITS-1:0]     SEG_SEL
);

  localparam int TICK_W = $clog2(CLK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TICK_W-1:0]   tick_cnt_r;
  logic                tick_s;
  logic [SCAN_W-1:0]   scan_cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic                step_up_s;
  logic                step_dn_s;
  logic [DIGITS:0]     carry_s;
  logic [DIGITS:0]     borrow_s;
  logic [4*DIGITS-1:0] count_s;
  logic                wrap_r;
  logic [3:0]          cur_digit_s;
  logic                upper_zero_s;
  logic                blank_s;
  logic [7:0]          seg_data_s;
  logic [DIGITS-1:0]   seg_sel_s;
  logic [7:0]          seg_data_r;
  logic [DIGITS-1:0]   seg_sel_r;

  assign tick_s = (tick_cnt_r == TICK_W'(CLK_DIV - 1));

  // Free-running tick divider; keeps running while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Load suppresses any coincident tick.
  assign step_up_s   = tick_s & en & ud & ~load;
  assign step_dn_s   = tick_s & en & ~ud & ~load;
  assign carry_s[0]  = 1'b1;
  assign borrow_s[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val[4*gi +: 4]),
        .inc        (step_up_s),
        .dec        (step_dn_s),
        .carry_in   (carry_s[gi]),
        .borrow_in  (borrow_s[gi]),
        .digit      (count_s[4*gi +: 4]),
        .carry_out  (carry_s[gi+1]),
        .borrow_out (borrow_s[gi+1])
      );
    end
  endgenerate

  assign count = count_s;

  // Wrap pulse: a carry or borrow rippled out of the top decade.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= (step_up_s & carry_s[DIGITS]) | (step_dn_s & borrow_s[DIGITS]);
    end
  end

  assign wrap = wrap_r;

  // Scan divider and digit index rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
    end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= '0;
      idx_r      <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      idx_r      <= idx_r;
    end
  end

  // Select the scanned digit and check whether it and all higher digits are 0.
  always_comb begin
    seg_sel_s    = '0;
    cur_digit_s  = 4'd0;
    upper_zero_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        seg_sel_s[i] = 1'b1;
        cur_digit_s  = count_s[4*i +: 4];
      end else begin
        seg_sel_s[i] = 1'b0;
      end
      if ((IDX_W'(i) >= idx_r) && (count_s[4*i +: 4] != 4'd0)) begin
        upper_zero_s = 1'b0;
      end else begin
        upper_zero_s = upper_zero_s;
      end
    end
  end

  // Digit 0 is never blanked, so a zero value still shows "0".
  always_comb begin
    blank_s = (LZB != 0) && (idx_r != '0) && upper_zero_s;
    if (blank_s) begin
      seg_data_s = SEG_BLANK;
    end else begin
      seg_data_s = seg_decode(cur_digit_s);
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_data_r <= 8'h00;
      seg_sel_r  <= '0;
    end else begin
      seg_data_r <= seg_data_s;
      seg_sel_r  <= seg_sel_s;
    end
  end

  assign SEG_DATA = seg_data_r;
  assign SEG_SEL  = seg_sel_r;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench for bcd_counter_display: directed scenarios plus a
// randomized phase, all compared cycle by cycle with an integer-valued model.
module tb_bcd_counter_display;

  localparam int CLK_DIV  = 4;
  localparam int SCAN_DIV = 2;
  localparam int DIGITS   = 2;
  localparam int LZB      = 1;
  localparam int W        = 4 * DIGITS;
  localparam logic [7:0] SEG_TAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                         8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic              clk = 1'b0;
  logic              rst;
  logic              ud;
  logic              en;
  logic              load;
  logic [W-1:0]      load_val;
  logic [W-1:0]      count;
  logic              wrap;
  logic [7:0]        seg_data;
  logic [DIGITS-1:0] seg_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers).
  int   m_val, m_tick, m_scan, m_idx, m_sel;
  logic m_wrap;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  bcd_counter_display #(
    .CLK_DIV (CLK_DIV),
    .SCAN_DIV(SCAN_DIV),
    .DIGITS  (DIGITS),
    .LZB     (LZB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ud      (ud),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .wrap    (wrap),
    .SEG_DATA(seg_data),
    .SEG_SEL (seg_sel)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int sum = 0;
    int nib;
    for (int k = 0; k < DIGITS; k++) begin
      nib = int'(v[4*k +: 4]);
      if (nib > 9) nib = 0;
      sum += nib * pow10(k);
    end
    return sum;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_tick = 0; m_scan = 0; m_idx = 0;
    m_wrap = 1'b0; m_data = 8'h00; m_sel = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_update();
    bit tick;
    int d;
    int top;
    top  = pow10(DIGITS);
    tick = (m_tick == CLK_DIV - 1);
    m_sel = 1 << m_idx;
    d = (m_val / pow10(m_idx)) % 10;
    if (LZB != 0 && m_idx > 0 && m_val < pow10(m_idx)) m_data = 8'h00;
    else m_data = SEG_TAB[d];
    if (load) begin
      m_val = bcd_to_int(load_val);
      m_wrap = 1'b0;
    end else if (tick && en) begin
      if (ud) begin
        m_wrap = (m_val == top - 1);
        m_val  = (m_val + 1) % top;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val == 0) ? top - 1 : m_val - 1;
      end
    end else begin
      m_wrap = 1'b0;
    end
    m_tick = (m_tick + 1) % CLK_DIV;
    if (m_scan == SCAN_DIV - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % DIGITS;
    end else begin
      m_scan = m_scan + 1;
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
    check_value("count", 32'(count), 32'(int_to_bcd(m_val)));
    check_value("wrap", 32'(wrap), 32'(m_wrap));
    check_value("seg_sel", 32'(seg_sel), 32'(m_sel));
    check_value("seg_data", 32'(seg_data), 32'(m_data));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  // Bounded wait until the next edge carries a tick; returns 1 when found.
  task automatic align_to_tick(output bit found);
    found = 1'b0;
    for (int k = 0; k < CLK_DIV + 1 && !found; k++) begin
      if (m_tick == CLK_DIV - 1) found = 1'b1;
      else step();
    end
  endtask

  initial begin
    int   wraps;
    bit   found;
    logic [W-1:0] held;
    rst = 1'b1; ud = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    #12;
    check_value("rst_count", 32'(count), 32'h0);
    check_value("rst_wrap", 32'(wrap), 32'h0);
    check_value("rst_seg_data", 32'(seg_data), 32'h0);
    check_value("rst_seg_sel", 32'(seg_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Count up 40 cycles: ten ticks, 00 -> 10, never wrapping.
    en = 1'b1; ud = 1'b1;
    wraps = 0;
    repeat (40) begin
      step();
      if (wrap) wraps++;
    end
    check_value("up40_count", 32'(count), 32'h10);
    check_value("up40_wraps", 32'(wraps), 32'd0);

    // 99 -> 00 on the next tick with one wrap pulse.
    do_load(8'h99);
    wraps = 0;
    repeat (2 * CLK_DIV) begin
      step();
      if (wrap) wraps++;
    end
    check_value("up_wrap_pulses", 32'(wraps), 32'd1);

    // 00 -> 99 counting down with one wrap pulse.
    ud = 1'b0;
    do_load(8'h00);
    wraps = 0;
    align_to_tick(found);
    check_value("align_dn", 32'(found), 32'd1);
    step();
    check_value("dn_wrap_count", 32'(count), 32'h99);
    check_value("dn_wrap_flag", 32'(wrap), 32'd1);
    step();
    check_value("dn_wrap_clear", 32'(wrap), 32'd0);

    // Scanning with blanking: 07 then 40, counter frozen.
    en = 1'b0;
    do_load(8'h07);
    repeat (8) step();
    do_load(8'h40);
    repeat (8) step();

    // Load coincident with a tick: invalid nibble forced to 0, no increment.
    en = 1'b1; ud = 1'b1;
    align_to_tick(found);
    check_value("align_load", 32'(found), 32'd1);
    do_load(8'h3C);
    check_value("load_tick_count", 32'(count), 32'h30);
    check_value("load_tick_wrap", 32'(wrap), 32'd0);

    // en=0: count frozen for 20 cycles while the display rotates.
    en = 1'b0;
    held = count;
    repeat (20) step();
    check_value("freeze_count", 32'(count), 32'(held));

    // Randomized phase.
    repeat (400) begin
      en = 1'($urandom_range(0, 3) != 0);
      ud = 1'($urandom);
      load = 1'($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      step();
    end
    load = 1'b0;

    // Asynchronous reset between edges with a non-zero display.
    en = 1'b1; ud = 1'b1;
    do_load(8'h57);
    repeat (3) step();
    @(posedge clk);
    model_update();
    #3 rst = 1'b1;
    #1;
    check_value("arst_count", 32'(count), 32'h0);
    check_value("arst_wrap", 32'(wrap), 32'h0);
    check_value("arst_seg_data", 32'(seg_data), 32'h0);
    check_value("arst_seg_sel", 32'(seg_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parameterised successor to the single-digit up/down counter top level. It integrates the tick divider, a DIGITS-wide BCD up/down counter with load, and a time-multiplexed seven-segment driver.
- Drives the board's SEG_DATA/SEG_SEL pins directly.
- Adds three features the previous version lacks: multi-digit decimal counting, a synchronous load, and leading-zero blanking.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per count tick (>=2)
- SCAN_DIV, 50_000, clk cycles per display digit slot (>=2)
- DIGITS, 4, number of BCD digits and display positions (1..5)
- LZB, 1, 1 = blank leading zeros; digit 0 is never blanked

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ud  in  1  1 = count up, 0 = count down; sampled on the tick cycle
- en  in  1  count enable; scanning continues while low
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0]
- count  out  4*DIGITS  current BCD value
- wrap  out  1  one-cycle pulse on wrap-around
- SEG_DATA  out  8  segments {dp,g,f,e,d,c,b,a}, active-high
- SEG_SEL  out  DIGITS  one-hot digit select, active-high, bit i = digit i

Behaviour:
- Reset is asynchronous and active-high. While rst=1 all state clears: count=0, tick counter=0, scan counter=0, scan index=0, wrap=0, SEG_DATA=0, SEG_SEL=0.
- Tick divider:
  - tick_cnt counts 0..CLK_DIV-1 and wraps.
  - tick is 1 for one cycle when tick_cnt==CLK_DIV-1.
  - The first tick occurs CLK_DIV cycles after reset release.
- Counter update, priority high to low:
  - load=1: count <= load_val. Any nibble >9 is stored as 0. A coincident tick is discarded and wrap=0.
  - tick && en && ud=1: BCD increment with ripple carry across digits. From all-9s the value goes to all-0s and wrap=1.
  - tick && en && ud=0: BCD decrement with ripple borrow. From all-0s the value goes to all-9s and wrap=1.
  - Otherwise count holds.
- Update timing:
  - count and wrap register on the clock edge after the tick/load cycle (1-cycle latency).
  - wrap is high for exactly that one cycle.
- en=0 freezes count only. The tick divider keeps running, so ticks are not stored or queued.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, scan index advances idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Display outputs (registered each cycle from idx and count, 1-cycle latency):
  - SEG_SEL = one-hot(idx).
  - SEG_DATA = decode(count digit idx). dp is always 0.
  - Blanking: if LZB=1, idx>0, and every digit at positions >= idx is 0, then SEG_DATA=0 while SEG_SEL is still driven.
- Decode table, hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- Reset mid-operation returns every output to its reset value immediately, with no completion of a tick in flight.
- DIGITS=1: SEG_SEL is constant 1 after reset release; blanking never applies.

Decomposition:
- Shared package (seg_pkg) holds:
  - the 10-entry segment pattern constants
  - SEG_BLANK=8'h00
  - the BCD_MAX=4'd9 constant
- Natural sub-module: bcd_digit. One decade register with inc/dec/load inputs, carry_in/borrow_in, and carry_out/borrow_out.
- The top level instantiates DIGITS copies via generate and chains the carry/borrow signals.

Test Plan:
Common settings for all cases: CLK_DIV=4, SCAN_DIV=2, DIGITS=2, LZB=1.
- Reset then en=1, ud=1 for 40 cycles -> count goes 00,01,...,10 with a step every 4 cycles; wrap stays 0 throughout.
- load=1, load_val=8'h99, then en=1, ud=1 until the next tick -> count=8'h00 and wrap pulses exactly one cycle.
- load_val=8'h00, ud=0, one tick -> count=8'h99, wrap=1 for one cycle.
- Scan with count=8'h07 -> SEG_SEL alternates 01/10 every 2 cycles. SEG_DATA=07 when SEG_SEL=01 and 00 (blanked) when SEG_SEL=10. With count=8'h40, SEG_DATA=66 when SEG_SEL=10 and 3F when SEG_SEL=01.
- load asserted on the same cycle as a tick, load_val=8'h3C -> count=8'h30 (invalid nibble forced to 0), no increment, wrap=0.
- en=0 for 20 cycles -> count constant while SEG_SEL keeps rotating.
- rst asserted mid-count, asynchronously between edges -> count, SEG_DATA, SEG_SEL and wrap go to 0 immediately.
